// File: rtl/serial_comparator_if.sv
// Handshake bundle for serial_comparator.
//   master : operand source / result consumer (drives beats and out_ready)
//   slave  : the comparator (drives in_ready, result flags and err)
// Signals:
//   in_valid/in_ready  beat handshake; in_first marks bit 1 of a pair
//   a_bit/b_bit        current operand bits
//   out_valid/out_ready result handshake; f1 = A>B, f2 = A==B, f3 = A<B
//   err                one-cycle framing-error pulse
interface serial_comparator_if;
   logic in_valid;
   logic in_ready;
   logic in_first;
   logic a_bit;
   logic b_bit;
   logic out_valid;
   logic out_ready;
   logic f1;
   logic f2;
   logic f3;
   logic err;

   modport master (
      output in_valid, in_first, a_bit, b_bit, out_ready,
      input  in_ready, out_valid, f1, f2, f3, err
   );

   modport slave (
      input  in_valid, in_first, a_bit, b_bit, out_ready,
      output in_ready, out_valid, f1, f2, f3, err
   );
endinterface

// File: rtl/serial_comparator.sv
// Bit-serial magnitude comparator. Two WIDTH-bit operands arrive one bit pair
// per accepted beat; once all WIDTH beats are in, a one-hot GT/EQ/LT result is
// held on the output handshake until taken.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    serial_comparator_if.slave (beat input, result output, err pulse)
// Parameters:
//   WIDTH      operand length, 1..16
//   MSB_FIRST  1: MSB arrives first, 0: LSB arrives first
//
// state | meaning
// IDLE  | waiting for a beat with in_first=1
// CMP   | collecting beats 2..WIDTH of a frame
// DONE  | result presented, waiting for out_ready
module serial_comparator #(
   parameter int WIDTH     = 2,
   parameter int MSB_FIRST = 1
) (
   input logic             clk,
   input logic             rst_n,
   serial_comparator_if.slave bus
);

   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH);
   localparam logic [CW-1:0] CNT_ONE = CW'(1);

   typedef enum logic [1:0] {IDLE, CMP, DONE} state_t;
   typedef enum logic [1:0] {D_EQ, D_GT, D_LT} dec_t;

   state_t          state, state_nxt;
   logic [CW-1:0]   count, count_nxt;
   dec_t            dec, dec_nxt;
   logic            err_nxt;

   logic            in_ready_q, in_ready_nxt;
   logic            out_valid_q, out_valid_nxt;
   logic [2:0]      f_q, f_nxt;
   logic            err_q;

   logic            accept;
   dec_t            beat_dec;

   // Acceptance uses the registered in_ready so the handshake seen by the
   // source is exactly the one the block acts on.
   assign accept   = bus.in_valid && in_ready_q;
   assign beat_dec = (bus.a_bit == bus.b_bit) ? D_EQ :
                     (bus.a_bit ? D_GT : D_LT);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         count       <= '0;
         dec         <= D_EQ;
         in_ready_q  <= 1'b0;
         out_valid_q <= 1'b0;
         f_q         <= 3'b000;
         err_q       <= 1'b0;
      end else begin
         state       <= state_nxt;
         count       <= count_nxt;
         dec         <= dec_nxt;
         in_ready_q  <= in_ready_nxt;
         out_valid_q <= out_valid_nxt;
         f_q         <= f_nxt;
         err_q       <= err_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      count_nxt = count;
      dec_nxt   = dec;
      err_nxt   = 1'b0;
      case (state)
         IDLE: begin
            if (accept) begin
               if (bus.in_first) begin
                  count_nxt = CNT_ONE;
                  dec_nxt   = beat_dec;
                  state_nxt = (WIDTH == 1) ? DONE : CMP;
               end else begin
                  err_nxt = 1'b1;
               end
            end
         end
         CMP: begin
            if (accept) begin
               if (bus.in_first) begin
                  // Restart: the offending beat becomes bit 1 of a new frame.
                  err_nxt   = 1'b1;
                  count_nxt = CNT_ONE;
                  dec_nxt   = beat_dec;
                  state_nxt = (WIDTH == 1) ? DONE : CMP;
               end else begin
                  count_nxt = count + CNT_ONE;
                  if (MSB_FIRST != 0) begin
                     // First differing bit is most significant; lock it in.
                     if (dec == D_EQ)
                        dec_nxt = beat_dec;
                  end else if (beat_dec != D_EQ) begin
                     // Later bits are more significant; let them overwrite.
                     dec_nxt = beat_dec;
                  end
                  if (count + CNT_ONE == CNT_MAX)
                     state_nxt = DONE;
               end
            end
         end
         DONE: begin
            if (bus.out_ready) begin
               state_nxt = IDLE;
               count_nxt = '0;
               dec_nxt   = D_EQ;
            end
         end
         default: begin
            state_nxt = IDLE;
            count_nxt = '0;
            dec_nxt   = D_EQ;
         end
      endcase
   end

   // Outputs are registered from the next state so they line up with it.
   always_comb begin
      in_ready_nxt  = (state_nxt != DONE);
      out_valid_nxt = (state_nxt == DONE);
      f_nxt         = 3'b000;
      if (state_nxt == DONE) begin
         case (dec_nxt)
            D_GT:    f_nxt = 3'b100;
            D_LT:    f_nxt = 3'b001;
            default: f_nxt = 3'b010;
         endcase
      end
   end

   assign bus.in_ready  = in_ready_q;
   assign bus.out_valid = out_valid_q;
   assign bus.f1        = f_q[2];
   assign bus.f2        = f_q[1];
   assign bus.f3        = f_q[0];
   assign bus.err       = err_q;

endmodule

// File: tb/tb_serial_comparator.sv
module tb_serial_comparator;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   // dut0: WIDTH=2 MSB first, dut1: WIDTH=2 LSB first, dut2: WIDTH=4 MSB first
   serial_comparator_if i0 ();
   serial_comparator_if i1 ();
   serial_comparator_if i2 ();

   serial_comparator #(.WIDTH(2), .MSB_FIRST(1)) u0 (.clk(clk), .rst_n(rst_n), .bus(i0));
   serial_comparator #(.WIDTH(2), .MSB_FIRST(0)) u1 (.clk(clk), .rst_n(rst_n), .bus(i1));
   serial_comparator #(.WIDTH(4), .MSB_FIRST(1)) u2 (.clk(clk), .rst_n(rst_n), .bus(i2));

   logic [2:0] v, fst, a, b, ordy;
   wire  [2:0] rdy, ov, er;
   wire  [8:0] fall;

   assign i0.in_valid = v[0];   assign i1.in_valid = v[1];   assign i2.in_valid = v[2];
   assign i0.in_first = fst[0]; assign i1.in_first = fst[1]; assign i2.in_first = fst[2];
   assign i0.a_bit    = a[0];   assign i1.a_bit    = a[1];   assign i2.a_bit    = a[2];
   assign i0.b_bit    = b[0];   assign i1.b_bit    = b[1];   assign i2.b_bit    = b[2];
   assign i0.out_ready = ordy[0]; assign i1.out_ready = ordy[1]; assign i2.out_ready = ordy[2];
   assign rdy  = {i2.in_ready, i1.in_ready, i0.in_ready};
   assign ov   = {i2.out_valid, i1.out_valid, i0.out_valid};
   assign er   = {i2.err, i1.err, i0.err};
   assign fall = {i2.f1, i2.f2, i2.f3, i1.f1, i1.f2, i1.f3, i0.f1, i0.f2, i0.f3};

   int checks = 0;
   int errors = 0;

   logic [2:0] q0[$];
   logic [2:0] q1[$];
   logic [2:0] q2[$];
   logic [2:0] prev_hs = 3'b000;

   function automatic logic [2:0] getf(input int d);
      return fall[d*3 +: 3];
   endfunction

   function automatic void push(input int d, input logic [2:0] e);
      case (d)
         0: q0.push_back(e);
         1: q1.push_back(e);
         default: q2.push_back(e);
      endcase
   endfunction

   function automatic int qsize(input int d);
      case (d)
         0: return q0.size();
         1: return q1.size();
         default: return q2.size();
      endcase
   endfunction

   function automatic logic [2:0] pop(input int d);
      case (d)
         0: return q0.pop_front();
         1: return q1.pop_front();
         default: return q2.pop_front();
      endcase
   endfunction

   task automatic chk(input string name, input logic [2:0] got, input logic [2:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got %b want %b at %0t", name, got, want, $time);
      end
   endtask

   // Result monitor: compare on every output handshake; a result must also
   // drop the cycle after it was taken.
   always @(negedge clk) begin
      logic [2:0] e;
      for (int d = 0; d < 3; d++) begin
         if (prev_hs[d]) begin
            checks++;
            if (ov[d] !== 1'b0) begin
               errors++;
               $display("FAIL out_valid_one_cycle dut%0d: got %b want 0", d, ov[d]);
            end
         end
         if (ov[d] && ordy[d]) begin
            checks++;
            if (qsize(d) == 0) begin
               errors++;
               $display("FAIL unexpected_result dut%0d: got %b want none", d, getf(d));
            end else begin
               e = pop(d);
               if (getf(d) !== e) begin
                  errors++;
                  $display("FAIL result dut%0d: got f=%b want f=%b at %0t", d, getf(d), e, $time);
               end
            end
         end
         prev_hs[d] = ov[d] && ordy[d];
      end
   end

   // Present one beat and hold it until the DUT accepts it; returns 1ns after
   // the accepting edge.
   task automatic beat(input int d, input logic first, input logic ab, input logic bb);
      int n;
      v[d] = 1'b1; fst[d] = first; a[d] = ab; b[d] = bb;
      n = 0;
      @(negedge clk);
      while (!rdy[d] && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!rdy[d]) begin
         checks++; errors++;
         $display("FAIL beat_timeout dut%0d: got in_ready 0 want 1", d);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic frame(input int d, input int w, input int av, input int bv);
      logic [15:0] aa, bb;
      int idx;
      aa = 16'(av); bb = 16'(bv);
      push(d, (av > bv) ? 3'b100 : (av == bv) ? 3'b010 : 3'b001);
      for (int i = 0; i < w; i++) begin
         idx = (d == 1) ? i : (w - 1 - i);
         beat(d, (i == 0), aa[idx], bb[idx]);
      end
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((q0.size() + q1.size() + q2.size()) != 0 && n < 100) begin
         @(negedge clk);
         n++;
      end
      if ((q0.size() + q1.size() + q2.size()) != 0) begin
         checks++; errors++;
         $display("FAIL drain_timeout: got %0d pending want 0", q0.size() + q1.size() + q2.size());
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0;
      v = '0; fst = '0; a = '0; b = '0; ordy = 3'b111;
      #12;
      chk("rst_in_ready", {2'b0, rdy[0]}, 3'b000);
      chk("rst_out_valid", ov, 3'b000);
      chk("rst_f", getf(0), 3'b000);
      chk("rst_err", er, 3'b000);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk("in_ready_after_rst", rdy, 3'b111);

      // all 16 pairs, in_valid held across frames
      for (int x = 0; x < 4; x++)
         for (int y = 0; y < 4; y++)
            frame(0, 2, x, y);
      v[0] = 1'b0;
      drain();

      // directed: A=10 B=01 on both bit orders, plus order-sensitive cases
      push(0, 3'b100); beat(0, 1, 1, 0); beat(0, 0, 0, 1); v[0] = 1'b0;
      push(1, 3'b100); beat(1, 1, 0, 1); beat(1, 0, 1, 0);
      push(1, 3'b001); beat(1, 1, 1, 0); beat(1, 0, 0, 1);
      frame(1, 2, 3, 3);
      frame(1, 2, 1, 3);
      v[1] = 1'b0;
      frame(2, 4, 9, 12);
      frame(2, 4, 12, 9);
      frame(2, 4, 10, 10);
      v[2] = 1'b0;
      drain();

      // backpressure on dut0
      ordy[0] = 1'b0;
      push(0, 3'b100); beat(0, 1, 1, 0); beat(0, 0, 1, 0);
      push(0, 3'b001);
      v[0] = 1'b1; fst[0] = 1'b1; a[0] = 1'b0; b[0] = 1'b1;
      repeat (5) begin
         @(negedge clk);
         chk("bp_f", getf(0), 3'b100);
         chk("bp_out_valid", {2'b0, ov[0]}, 3'b001);
         chk("bp_in_ready", {2'b0, rdy[0]}, 3'b000);
      end
      @(posedge clk);
      #1;
      ordy[0] = 1'b1;
      beat(0, 1, 0, 1); beat(0, 0, 0, 1);
      v[0] = 1'b0;
      drain();

      // framing restart on dut2: new frame A=0101 B=0110 -> LT
      push(2, 3'b001);
      beat(2, 1, 1, 0);
      beat(2, 1, 0, 0);
      chk("err_restart", {2'b0, er[2]}, 3'b001);
      beat(2, 0, 1, 1);
      chk("err_restart_clear", {2'b0, er[2]}, 3'b000);
      beat(2, 0, 0, 1);
      beat(2, 0, 1, 0);
      v[2] = 1'b0;
      drain();

      // in_first=0 beat in IDLE
      beat(0, 0, 1, 0);
      chk("err_idle", {2'b0, er[0]}, 3'b001);
      chk("err_idle_no_valid", {2'b0, ov[0]}, 3'b000);
      v[0] = 1'b0;
      @(posedge clk);
      #1;
      chk("err_idle_clear", {2'b0, er[0]}, 3'b000);
      chk("err_idle_no_valid2", {2'b0, ov[0]}, 3'b000);

      // reset mid-frame
      beat(0, 1, 1, 1);
      v[0] = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      chk("midrst_in_ready", {2'b0, rdy[0]}, 3'b000);
      chk("midrst_out_valid", ov, 3'b000);
      chk("midrst_f", getf(0), 3'b000);
      chk("midrst_err", er, 3'b000);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk("midrst_no_err", er, 3'b000);
      frame(0, 2, 3, 3);
      v[0] = 1'b0;
      drain();

      chk("queues_empty", 3'(q0.size() + q1.size() + q2.size()), 3'b000);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/serial_comparator.md
SERIAL_COMPARATOR -- requirements
Module: serial_comparator

Interface
REQ-001 Parameter WIDTH, default 2, operand length in bits; legal range 1..16.
REQ-002 Parameter MSB_FIRST, default 1; 1 = bits arrive MSB first, 0 = LSB first.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset; asynchronous, active-low.
REQ-005 in_valid  input  1  a_bit/b_bit/in_first carry a valid beat.
REQ-006 in_ready  output  1  block accepts a beat; a beat transfers when in_valid && in_ready at a rising edge.
REQ-007 in_first  input  1  beat is the first bit of a new operand pair.
REQ-008 a_bit  input  1  current bit of operand A.
REQ-009 b_bit  input  1  current bit of operand B.
REQ-010 out_valid  output  1  result on f1/f2/f3 is valid.
REQ-011 out_ready  input  1  consumer accepts the result; transfer when out_valid && out_ready.
REQ-012 f1  output  1  A > B.
REQ-013 f2  output  1  A == B.
REQ-014 f3  output  1  A < B.
REQ-015 err  output  1  one-cycle pulse on a framing error.

Function
REQ-016 FSM states: IDLE, CMP, DONE; all outputs are registered.
REQ-017 IDLE: in_ready=1, out_valid=0; an accepted beat with in_first=1 starts a frame, with bit count=1 and the decision register loaded from that beat; the next state is CMP, or DONE if WIDTH=1.
REQ-018 IDLE: an accepted beat with in_first=0 is discarded, err pulses the next cycle, and the state stays IDLE.
REQ-019 CMP: in_ready=1; each accepted beat with in_first=0 increments the count and updates the decision; the beat that makes count==WIDTH moves the state to DONE.
REQ-020 CMP: an accepted beat with in_first=1 pulses err, abandons the partial frame, and restarts with that beat as bit 1.
REQ-021 CMP: cycles with in_valid=0 leave the state and count unchanged; there is no timeout.
REQ-022 Decision, MSB_FIRST=1: the first beat with a_bit!=b_bit fixes the result (a_bit=1 gives GT, else LT); later beats do not change it.
REQ-023 Decision, MSB_FIRST=0: every beat with a_bit!=b_bit overwrites the result, so the last differing bit decides.
REQ-024 If no beat differs, the result is EQ.
REQ-025 DONE: in_ready=0, out_valid=1; exactly one of f1/f2/f3 is 1, and all three are stable until out_ready=1.
REQ-026 Latency: out_valid rises in the cycle after the WIDTH-th beat is accepted.
REQ-027 DONE with out_ready=1: the next state is IDLE, out_valid=0, f1=f2=f3=0, and in_ready=1 from the next cycle; there is no overlap with the next frame.
REQ-028 Outside DONE, f1=f2=f3=0.
REQ-029 The count register is ceil(log2(WIDTH+1)) bits wide and never exceeds WIDTH.

Reset
REQ-030 rst_n=0 forces, asynchronously: state=IDLE, count=0, decision=EQ, in_ready=0, out_valid=0, f1=f2=f3=0, err=0.
REQ-031 in_ready becomes 1 on the first rising edge after rst_n deasserts.
REQ-032 Reset asserted mid-frame or in DONE discards the frame and any pending result; no err pulse is produced.

Verification
REQ-033 WIDTH=2, MSB_FIRST=1: all 16 (A,B) pairs, each driven as 2 beats with in_valid held high and out_ready=1 -> f1/f2/f3 match A>B, A==B, A<B; out_valid lasts 1 cycle per pair.
REQ-034 WIDTH=2, MSB_FIRST=1: A=10, B=01 -> f1=1, f2=0, f3=0. WIDTH=2, MSB_FIRST=0: bits sent LSB first for the same values -> f1=1.
REQ-035 Backpressure: out_ready=0 for 5 cycles after out_valid rises -> f outputs stable, in_ready=0, and a beat offered meanwhile is not consumed.
REQ-036 Framing: in_first=1 on beat 2 of a WIDTH=4 frame -> err pulses 1 cycle, the frame restarts, and the result reflects only the new 4 beats.
REQ-037 in_first=0 beat in IDLE -> err pulses and out_valid stays 0.
REQ-038 rst_n pulsed low after beat 1 of 2 -> all outputs are 0 immediately; a following full frame A=11, B=11 -> f2=1.
